rx_data_link_layer: RTL and testbench

Receive-side data link layer: the far end of the TX data link layer's TLP word stream. Accepts framed TLPs one 32-bit word per cycle, verifies the LCRC and sequence number, buffers the TLP store-and-forward, and emits single-cycle `ack`/`nack` pulses back to the transmitter. Good in-order TLPs are forwarded to the RX transaction layer; all other frames are dropped.

---
 rtl/rx_dll_pkg.sv | 34 +++
 rtl/rx_dll_tlp_buffer.sv | 52 +++++
 rtl/rx_data_link_layer.sv | 178 +++++++++++++++++
 tb/tb_rx_data_link_layer.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_dll_pkg.sv
// Shared definitions for the receive data link layer: FSM states, header
// field positions and the LCRC step function used by both DLL directions.
package rx_dll_pkg;

    localparam int unsigned DW          = 32;
    localparam int unsigned HDR_SEQ_LSB = 16;
    localparam int unsigned HDR_SEQ_MSB = 27;
    localparam int unsigned HDR_LEN_LSB = 0;
    localparam int unsigned HDR_LEN_MSB = 7;
    localparam int unsigned CNT_W       = 9;

    localparam logic [DW-1:0] CRC_POLY = 32'h04C1_1DB7;
    localparam logic [DW-1:0] CRC_INIT = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RECV = 3'd1,
        ST_LCRC = 3'd2,
        ST_SKIP = 3'd3,
        ST_FWD  = 3'd4
    } state_e;

    // One 32-bit CRC step, data fed MSB first, no reflection or inversion.
    function automatic logic [DW-1:0] crc32_dw(input logic [DW-1:0] crc,
                                               input logic [DW-1:0] data);
        logic [DW-1:0] c;
        c = crc ^ data;
        for (int i = 0; i < 32; i++) begin
            c = c[31] ? ({c[30:0], 1'b0} ^ CRC_POLY) : {c[30:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/rx_dll_tlp_buffer.sv
// Store-and-forward TLP body buffer: write pointer rewinds on each header,
// read pointer walks the stored words during forwarding.
module rx_dll_tlp_buffer
    import rx_dll_pkg::*;
#(
    parameter int unsigned MAX_TLP_DW = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clr_i,
    input  logic          wr_en_i,
    input  logic [DW-1:0] wr_data_i,
    input  logic          rd_adv_i,
    output logic [DW-1:0] rd_data_o_c
);

    localparam int unsigned AW = (MAX_TLP_DW > 1) ? $clog2(MAX_TLP_DW) : 1;

    logic [DW-1:0] mem_q [MAX_TLP_DW];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_en_i)  wr_ptr_d = wr_ptr_q + AW'(1);
            if (rd_adv_i) rd_ptr_d = rd_ptr_q + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Payload storage carries no reset; contents are only read after a full write.
    always_ff @(posedge clk) begin
        if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign rd_data_o_c = mem_q[rd_ptr_q];

endmodule

// File: rtl/rx_data_link_layer.sv
// Receive data link layer: checks LCRC and sequence of each framed TLP,
// answers with ack/nack and forwards good in-order TLPs from a buffer.
module rx_data_link_layer
    import rx_dll_pkg::*;
#(
    parameter int unsigned MAX_TLP_DW = 16,
    parameter int unsigned SEQ_W      = 12
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [DW-1:0] tlp_data_in,
    input  logic          tlp_data_in_valid,
    output logic          tlp_data_in_ready,
    output logic [DW-1:0] tlp_data_out,
    output logic          tlp_data_out_valid,
    input  logic          tlp_data_out_ready,
    output logic          tlp_data_out_last,
    output logic          ack,
    output logic          nack
);

    localparam logic [SEQ_W-1:0] SEQ_HALF = {1'b1, {(SEQ_W-1){1'b0}}};

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        len_q, len_d;
    logic [SEQ_W-1:0]  seq_q, seq_d;
    logic [SEQ_W-1:0]  exp_seq_q, exp_seq_d;
    logic [DW-1:0]     crc_q, crc_d;
    logic              ack_q, ack_d, nack_q, nack_d;
    logic              in_ready_q, in_ready_d;
    logic [DW-1:0]     out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;

    logic              in_fire, out_fire;
    logic              buf_clr, buf_wr, buf_adv;
    logic [DW-1:0]     buf_rd_data;
    logic [SEQ_W-1:0]  hdr_seq, seq_diff;
    logic [7:0]        hdr_len;
    logic              len_ok;

    rx_dll_tlp_buffer #(.MAX_TLP_DW(MAX_TLP_DW)) u_buf (
        .clk         (clk),
        .reset_n     (reset_n),
        .clr_i       (buf_clr),
        .wr_en_i     (buf_wr),
        .wr_data_i   (tlp_data_in),
        .rd_adv_i    (buf_adv),
        .rd_data_o_c (buf_rd_data)
    );

    assign in_fire  = tlp_data_in_valid & in_ready_q;
    assign out_fire = out_valid_q & tlp_data_out_ready;
    assign hdr_seq  = SEQ_W'(tlp_data_in[HDR_SEQ_MSB:HDR_SEQ_LSB]);
    assign hdr_len  = tlp_data_in[HDR_LEN_MSB:HDR_LEN_LSB];
    assign len_ok   = (hdr_len != 8'd0) && (32'(hdr_len) <= MAX_TLP_DW);
    // Positive distance behind expected (in the lower half window) marks a duplicate.
    assign seq_diff = exp_seq_q - seq_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        seq_d       = seq_q;
        exp_seq_d   = exp_seq_q;
        crc_d       = crc_q;
        ack_d       = 1'b0;
        nack_d      = 1'b0;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        buf_clr     = 1'b0;
        buf_wr      = 1'b0;
        buf_adv     = 1'b0;

        case (state_q)
            ST_IDLE: if (in_fire) begin
                seq_d   = hdr_seq;
                len_d   = hdr_len;
                crc_d   = crc32_dw(CRC_INIT, tlp_data_in);
                buf_clr = 1'b1;
                if (len_ok) begin
                    cnt_d   = '0;
                    state_d = ST_RECV;
                end else begin
                    cnt_d   = CNT_W'(hdr_len) + CNT_W'(1);
                    state_d = ST_SKIP;
                end
            end
            ST_RECV: if (in_fire) begin
                buf_wr = 1'b1;
                crc_d  = crc32_dw(crc_q, tlp_data_in);
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q + CNT_W'(1) == CNT_W'(len_q)) state_d = ST_LCRC;
            end
            ST_LCRC: if (in_fire) begin
                state_d = ST_IDLE;
                if (tlp_data_in != crc_q) begin
                    nack_d = 1'b1;
                end else if (seq_diff == '0) begin
                    ack_d       = 1'b1;
                    exp_seq_d   = exp_seq_q + SEQ_W'(1);
                    out_valid_d = 1'b1;
                    out_data_d  = buf_rd_data;
                    out_last_d  = (len_q == 8'd1);
                    buf_adv     = 1'b1;
                    cnt_d       = '0;
                    state_d     = ST_FWD;
                end else if (seq_diff < SEQ_HALF) begin
                    ack_d = 1'b1;
                end else begin
                    nack_d = 1'b1;
                end
            end
            ST_SKIP: if (in_fire) begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    nack_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_FWD: if (out_fire) begin
                if (out_last_q) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    cnt_d      = cnt_q + CNT_W'(1);
                    out_data_d = buf_rd_data;
                    out_last_d = (cnt_q + CNT_W'(2) == CNT_W'(len_q));
                    buf_adv    = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        in_ready_d = (state_d != ST_FWD);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            len_q       <= '0;
            seq_q       <= '0;
            exp_seq_q   <= '0;
            crc_q       <= CRC_INIT;
            ack_q       <= 1'b0;
            nack_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            seq_q       <= seq_d;
            exp_seq_q   <= exp_seq_d;
            crc_q       <= crc_d;
            ack_q       <= ack_d;
            nack_q      <= nack_d;
            in_ready_q  <= in_ready_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    assign tlp_data_in_ready  = in_ready_q;
    assign tlp_data_out       = out_data_q;
    assign tlp_data_out_valid = out_valid_q;
    assign tlp_data_out_last  = out_last_q;
    assign ack                = ack_q;
    assign nack               = nack_q;

endmodule

// File: tb/tb_rx_data_link_layer.sv
// Self-checking bench for rx_data_link_layer: directed and random frames
// compared against a frame-level reference model of LCRC and sequencing.
module tb_rx_data_link_layer;

    localparam int MAX     = 16;
    localparam int SEQ_W   = 12;
    localparam int SEQ_MOD = 1 << SEQ_W;
    localparam int HALF    = 5;

    typedef logic [31:0] wq_t[$];

    logic        clk;
    logic        reset_n;
    logic [31:0] tlp_data_in;
    logic        tlp_data_in_valid;
    logic        tlp_data_in_ready;
    logic [31:0] tlp_data_out;
    logic        tlp_data_out_valid;
    logic        tlp_data_out_ready;
    logic        tlp_data_out_last;
    logic        ack;
    logic        nack;

    rx_data_link_layer #(.MAX_TLP_DW(MAX), .SEQ_W(SEQ_W)) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .tlp_data_in        (tlp_data_in),
        .tlp_data_in_valid  (tlp_data_in_valid),
        .tlp_data_in_ready  (tlp_data_in_ready),
        .tlp_data_out       (tlp_data_out),
        .tlp_data_out_valid (tlp_data_out_valid),
        .tlp_data_out_ready (tlp_data_out_ready),
        .tlp_data_out_last  (tlp_data_out_last),
        .ack                (ack),
        .nack               (nack)
    );

    int  n_assert = 0;
    int  n_fail   = 0;
    int  ack_cnt  = 0;
    int  nack_cnt = 0;
    int  rdy_mode = 0;
    int  exp_seq  = 0;
    time ack_t, nack_t, first_valid_t, trailer_t, acc_t;
    logic [31:0] out_q[$];
    logic        last_q[$];
    logic [31:0] prev_data;
    logic        prev_last, prev_stall, prev_valid, prev_done;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #HALF clk = ~clk;
    end

    // Output-side ready pattern: 0 always, 1 toggling, 2 random, 3 held low.
    initial begin
        tlp_data_out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       tlp_data_out_ready = 1'b1;
                1:       tlp_data_out_ready = ~tlp_data_out_ready;
                2:       tlp_data_out_ready = 1'($urandom_range(0, 1));
                default: tlp_data_out_ready = 1'b0;
            endcase
        end
    end

    // Output monitor: pulse bookkeeping, stall stability and word capture.
    initial begin
        prev_stall = 1'b0; prev_valid = 1'b0; prev_done = 1'b0;
        prev_data = '0; prev_last = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_stall = 1'b0; prev_valid = 1'b0; prev_done = 1'b0;
            end else begin
                if (ack)  begin ack_cnt++;  ack_t  = $time; end
                if (nack) begin nack_cnt++; nack_t = $time; end
                check("ack_nack_excl", 32'(ack & nack), 32'd0);
                if (tlp_data_out_valid) check("in_ready_low_fwd", 32'(tlp_data_in_ready), 32'd0);
                if (prev_stall) begin
                    check("stall_valid", 32'(tlp_data_out_valid), 32'd1);
                    check("stall_data", tlp_data_out, prev_data);
                    check("stall_last", 32'(tlp_data_out_last), 32'(prev_last));
                end
                if (prev_done) check("ready_after_last", 32'(tlp_data_in_ready), 32'd1);
                if (tlp_data_out_valid && !prev_valid) first_valid_t = $time;
                if (tlp_data_out_valid && tlp_data_out_ready) begin
                    out_q.push_back(tlp_data_out);
                    last_q.push_back(tlp_data_out_last);
                end
                prev_stall = tlp_data_out_valid & ~tlp_data_out_ready;
                prev_done  = tlp_data_out_valid & tlp_data_out_ready & tlp_data_out_last;
                prev_valid = tlp_data_out_valid;
                prev_data  = tlp_data_out;
                prev_last  = tlp_data_out_last;
            end
        end
    end

    // Bit-serial CRC-32 over a word list, MSB of each word first.
    function automatic logic [31:0] model_crc(input wq_t w);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFF_FFFF;
        foreach (w[k]) begin
            for (int b = 31; b >= 0; b--) begin
                fb = c[31] ^ w[k][b];
                c  = {c[30:0], 1'b0};
                if (fb) c = c ^ 32'h04C1_1DB7;
            end
        end
        return c;
    endfunction

    // 0 = forward, 1 = duplicate (ack, drop), 2 = reject (nack).
    function automatic int predict(input int seq, input int len, input bit bad);
        int d;
        if (len == 0 || len > MAX) return 2;
        if (bad) return 2;
        d = (exp_seq - seq + SEQ_MOD) % SEQ_MOD;
        if (d == 0) return 0;
        if (d < SEQ_MOD / 2) return 1;
        return 2;
    endfunction

    function automatic wq_t rand_body(input int n);
        wq_t q;
        for (int i = 0; i < n; i++) q.push_back($urandom);
        return q;
    endfunction

    function automatic logic [31:0] make_hdr(input int seq, input int len);
        logic [31:0] h;
        h = $urandom;
        h[27:16] = 12'(seq);
        h[7:0]   = 8'(len);
        return h;
    endfunction

    task automatic drive_word(input logic [31:0] w, input bit bub);
        int guard;
        if (bub) begin
            for (int k = 0; k < 3 && $urandom_range(0, 2) == 0; k++) begin
                tlp_data_in_valid = 1'b0;
                tlp_data_in       = $urandom;
                @(posedge clk); #1;
            end
        end
        tlp_data_in       = w;
        tlp_data_in_valid = 1'b1;
        guard = 0;
        @(negedge clk);
        while (!tlp_data_in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) check("in_ready_timeout", 32'(tlp_data_in_ready), 32'd1);
        @(posedge clk);
        acc_t = $time;
        #1;
        tlp_data_in_valid = 1'b0;
    endtask

    task automatic run_frame(input int seq, input int len, input wq_t body, input bit bad, input bit bub);
        wq_t         words;
        logic [31:0] crc;
        int          outcome, a0, n0, guard;
        words = {make_hdr(seq, len)};
        foreach (body[k]) words.push_back(body[k]);
        crc = model_crc(words);
        if (bad) crc[0] = ~crc[0];
        outcome = predict(seq, len, bad);
        a0 = ack_cnt;
        n0 = nack_cnt;
        out_q.delete();
        last_q.delete();
        foreach (words[k]) drive_word(words[k], bub);
        drive_word(crc, bub);
        trailer_t = acc_t;
        @(negedge clk); #1;
        check("resp_ack_count", 32'(ack_cnt - a0), 32'(outcome != 2));
        check("resp_nack_count", 32'(nack_cnt - n0), 32'(outcome == 2));
        check("resp_time", 32'(outcome == 2 ? nack_t : ack_t), 32'(trailer_t + HALF));
        if (outcome == 0) begin
            check("first_valid_time", 32'(first_valid_t), 32'(trailer_t + HALF));
            guard = 0;
            while (out_q.size() < len && guard < 8 * len + 20) begin
                @(negedge clk); #1;
                guard++;
            end
            check("out_count", 32'(out_q.size()), 32'(len));
            for (int i = 0; i < len && i < out_q.size(); i++) begin
                check("out_data", out_q[i], body[i]);
                check("out_last", 32'(last_q[i]), 32'(i == len - 1));
            end
            exp_seq = (exp_seq + 1) % SEQ_MOD;
        end else begin
            repeat (2) @(negedge clk);
            #1;
            check("no_output", 32'(out_q.size()), 32'd0);
        end
        check("single_pulse", 32'(ack_cnt - a0 + nack_cnt - n0), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic do_reset(input int cycles);
        reset_n           = 1'b0;
        tlp_data_in_valid = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(tlp_data_in_ready), 32'd0);
        check("rst_out_data", tlp_data_out, 32'd0);
        check("rst_out_valid", 32'(tlp_data_out_valid), 32'd0);
        check("rst_out_last", 32'(tlp_data_out_last), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_nack", 32'(nack), 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_reset", 32'(tlp_data_in_ready), 32'd1);
        exp_seq = 0;
        out_q.delete();
        last_q.delete();
    endtask

    initial begin
        wq_t         b;
        wq_t         words;
        int          s, l, a0, n0;
        logic [31:0] crc;

        reset_n           = 1'b0;
        tlp_data_in       = '0;
        tlp_data_in_valid = 1'b0;
        do_reset(3);

        // Directed: good frame, corrupted LCRC, replay, duplicate and ahead sequence.
        b = {32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
        run_frame(0, 3, b, 1'b0, 1'b0);
        b = rand_body(3);
        run_frame(exp_seq, 3, b, 1'b1, 1'b0);
        run_frame(exp_seq, 3, b, 1'b0, 1'b0);
        run_frame(0, 3, b, 1'b0, 1'b0);
        run_frame((exp_seq + 5) % SEQ_MOD, 2, rand_body(2), 1'b0, 1'b0);

        // Length boundaries: empty and oversized frames are skipped whole.
        run_frame(exp_seq, 0, rand_body(0), 1'b0, 1'b0);
        run_frame(exp_seq, MAX + 1, rand_body(MAX + 1), 1'b0, 1'b0);
        run_frame(exp_seq, 1, rand_body(1), 1'b0, 1'b0);

        // Full-size TLP with toggling output ready and input bubbles.
        rdy_mode = 1;
        run_frame(exp_seq, MAX, rand_body(MAX), 1'b0, 1'b1);
        rdy_mode = 0;

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 5))
                0, 1, 2: s = exp_seq;
                3:       s = (exp_seq + SEQ_MOD - int'($urandom_range(1, 3))) % SEQ_MOD;
                4:       s = (exp_seq + int'($urandom_range(1, 3))) % SEQ_MOD;
                default: s = int'($urandom_range(0, SEQ_MOD - 1));
            endcase
            case ($urandom_range(0, 7))
                0:       l = 0;
                1:       l = MAX + 1 + int'($urandom_range(0, 2));
                default: l = int'($urandom_range(1, MAX));
            endcase
            rdy_mode = int'($urandom_range(0, 2));
            run_frame(s, l, rand_body(l), 1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)));
        end
        rdy_mode = 0;

        // Full sequence-space lap, crossing 4095 -> 0, then a duplicate across the wrap.
        repeat (SEQ_MOD) run_frame(exp_seq, 1, rand_body(1), 1'b0, 1'b0);
        run_frame((exp_seq + SEQ_MOD - 1) % SEQ_MOD, 1, rand_body(1), 1'b0, 1'b0);

        // Reset in the middle of body reception.
        a0 = ack_cnt;
        n0 = nack_cnt;
        drive_word(make_hdr(exp_seq, 5), 1'b0);
        drive_word($urandom, 1'b0);
        drive_word($urandom, 1'b0);
        do_reset(2);
        repeat (3) @(negedge clk);
        #1;
        check("recv_reset_no_ack", 32'(ack_cnt - a0), 32'd0);
        check("recv_reset_no_nack", 32'(nack_cnt - n0), 32'd0);
        @(posedge clk); #1;
        run_frame(0, 4, rand_body(4), 1'b0, 1'b0);

        // Reset while a forwarded TLP is stalled at the output.
        rdy_mode = 3;
        @(posedge clk); #1;
        b = rand_body(2);
        words = {make_hdr(exp_seq, 2)};
        foreach (b[k]) words.push_back(b[k]);
        crc = model_crc(words);
        foreach (words[k]) drive_word(words[k], 1'b0);
        drive_word(crc, 1'b0);
        repeat (3) @(negedge clk);
        #1;
        check("fwd_stalled_valid", 32'(tlp_data_out_valid), 32'd1);
        check("fwd_stalled_data", tlp_data_out, b[0]);
        do_reset(2);
        rdy_mode = 0;
        @(posedge clk); #1;
        run_frame(0, 2, rand_body(2), 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
